// File: rtl/trap_filter_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// trap_ctrl_pkg
// Shared definitions for the trapezoidal filter controller:
//   - controller state encoding (IDLE/FLUSH/WARM/RUN)
//   - minimum legal rise/fall length K
//   - warm-up counter width rule
// ---------------------------------------------------------------------------
package trap_ctrl_pkg;

    // Controller state encoding, also exported on the 'state' port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        WARM  = 2'd2,
        RUN   = 2'd3
    } trap_state_e;

    // The same encoding as plain constants, for legacy code that keeps the
    // state in a raw logic vector.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_WARM  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    // Smallest K the filter supports.
    localparam int TRAP_MIN_K = 3;

    // The warm-up length K + L + 2 + PIPE_LAT needs two bits more than K/L
    // so it can never overflow.
    function automatic int warm_width(input int delay_width);
        return delay_width + 2;
    endfunction

endpackage

// File: rtl/trap_filter_ctrl_if.sv
// ---------------------------------------------------------------------------
// trap_filter_ctrl_if
// Configuration handshake between the PS-side register bank (master) and
// the trap filter controller (slave).
//   cfg_k, cfg_l   requested K and L (DELAY_WIDTH bits)
//   cfg_mult       requested signed decay multiplier
//   cfg_valid      request present
//   cfg_ready      controller can accept a request
//   cfg_err        one-cycle pulse: the accepted request was rejected
// ---------------------------------------------------------------------------
interface trap_filter_ctrl_if #(
    parameter int DELAY_WIDTH = 14
);
    logic [DELAY_WIDTH-1:0] cfg_k;
    logic [DELAY_WIDTH-1:0] cfg_l;
    logic [15:0]            cfg_mult;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic                   cfg_err;

    modport master (
        output cfg_k, cfg_l, cfg_mult, cfg_valid,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_k, cfg_l, cfg_mult, cfg_valid,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/trap_filter_ctrl_warm_counter.sv
// ---------------------------------------------------------------------------
// trap_warm_counter
// Loadable down-counter used to time both the FLUSH and WARM phases.
//   clk, reset  clock and synchronous active-high reset
//   load        load load_val (has priority over enable)
//   load_val    number of cycles to count
//   enable      decrement by one this cycle
//   done        registered flag: the count currently equals 1, i.e. this is
//               the last cycle of the loaded interval
// ---------------------------------------------------------------------------
module trap_warm_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Done is computed alongside the count so it is a flop output and
    // costs no compare on the consumer side.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            done  <= 1'b0;
        end else if (load) begin
            count <= load_val;
            done  <= (load_val == WIDTH'(1));
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
            done  <= (count == WIDTH'(2));
        end
    end

endmodule

// File: rtl/trap_filter_ctrl.sv
// ---------------------------------------------------------------------------
// trap_filter_ctrl
// Sequencer and configuration owner for the trapezoidal filter. Accepts and
// checks new K/L/multiplier settings, drives the live filter parameters and
// the filter reset, flushes and warms up the filter after every change and
// lets only settled output samples through.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cfg_if (slave)      configuration handshake (K, L, mult, valid/ready, err)
//   flt_aresetn         filter reset, active low, high only in WARM/RUN
//   flt_kdelay/ldelay   live K and L to the filter
//   flt_mult            live decay multiplier to the filter
//   flt_tvalid/tdata    filter output stream
//   m_axis_tvalid/tdata gated, registered output stream
//   busy                high in FLUSH or WARM
//   state               IDLE=0, FLUSH=1, WARM=2, RUN=3
//   out_count           settled output beats since last FLUSH entry
//
// Build option: define TRAP_CTRL_STATS_EN to build the saturating out_count
// beat counter; otherwise out_count is tied to zero.
// ---------------------------------------------------------------------------
module trap_filter_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int DELAY_WIDTH = 14,
    parameter int PIPE_LAT    = 4,
    parameter int FLUSH_CYC   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    trap_filter_ctrl_if.slave       cfg_if,
    output logic                    flt_aresetn,
    output logic [DELAY_WIDTH-1:0]  flt_kdelay,
    output logic [DELAY_WIDTH-1:0]  flt_ldelay,
    output logic [15:0]             flt_mult,
    input  logic                    flt_tvalid,
    input  logic [2*DATA_WIDTH-1:0] flt_tdata,
    output logic                    m_axis_tvalid,
    output logic [2*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    busy,
    output logic [1:0]              state,
    output logic [31:0]             out_count
);

    localparam int CW = warm_width(DELAY_WIDTH);

    logic          accept;
    logic          cfg_ok;
    logic          restart;
    logic          run_gate;
    logic          cnt_load;
    logic [CW-1:0] cnt_val;
    logic          cnt_done;
    logic [CW-1:0] warm_len;
    logic [1:0]    next_state;
    logic          err_q;

    // Requests are only blocked while the filter is being flushed.
    assign cfg_if.cfg_ready = (state != ST_FLUSH);
    assign cfg_if.cfg_err   = err_q;

    assign accept  = cfg_if.cfg_valid && cfg_if.cfg_ready;
    assign cfg_ok  = (cfg_if.cfg_k >= DELAY_WIDTH'(TRAP_MIN_K)) &&
                     (cfg_if.cfg_l >= cfg_if.cfg_k);
    assign restart = accept && cfg_ok;

    // A restart in RUN must already blank the output on the same edge, so
    // the first FLUSH cycle never shows a beat.
    assign run_gate = (state == ST_RUN) && !restart;

    // WARM and RUN are the two states with state[1] set; decoding from the
    // state flop keeps the filter reset glitch-free.
    assign flt_aresetn = state[1];
    assign busy        = (state == ST_FLUSH) || (state == ST_WARM);

    // The warm-up length uses the live parameters, which were captured on
    // the accepting edge and are therefore stable for the whole FLUSH.
    assign warm_len = CW'(flt_kdelay) + CW'(flt_ldelay) + CW'(2 + PIPE_LAT);

    // One counter times both phases: loaded with FLUSH_CYC on a restart and
    // with the warm-up length on the last FLUSH cycle.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        if (restart) begin
            cnt_load = 1'b1;
            cnt_val  = CW'(FLUSH_CYC);
        end else if ((state == ST_FLUSH) && cnt_done) begin
            cnt_load = 1'b1;
            cnt_val  = warm_len;
        end
    end

    trap_warm_counter #(
        .WIDTH (CW)
    ) u_warm_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .enable   (busy),
        .done     (cnt_done)
    );

    // Next-state logic: a valid request wins from any state; otherwise the
    // timed phases advance when the counter reports its last cycle.
    always_comb begin
        next_state = state;
        if (restart) begin
            next_state = ST_FLUSH;
        end else begin
            case (state)
                ST_FLUSH: if (cnt_done) next_state = ST_WARM;
                ST_WARM:  if (cnt_done) next_state = ST_RUN;
                default:  next_state = state;
            endcase
        end
    end

    // State, live parameters, error pulse and the gated output register.
    // An invalid request only produces the error pulse and touches nothing
    // else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            err_q         <= 1'b0;
            flt_kdelay    <= '0;
            flt_ldelay    <= '0;
            flt_mult      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            state         <= next_state;
            err_q         <= accept && !cfg_ok;
            m_axis_tvalid <= run_gate && flt_tvalid;
            if (restart) begin
                flt_kdelay <= cfg_if.cfg_k;
                flt_ldelay <= cfg_if.cfg_l;
                flt_mult   <= cfg_if.cfg_mult;
            end
            if (state == ST_RUN) begin
                m_axis_tdata <= flt_tdata;
            end
        end
    end

`ifdef TRAP_CTRL_STATS_EN
    // Settled-beat counter: counts every beat let through in RUN, clears
    // when a new configuration starts a flush and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_count <= '0;
        end else if (restart) begin
            out_count <= '0;
        end else if (run_gate && flt_tvalid && (out_count != '1)) begin
            out_count <= out_count + 32'd1;
        end
    end
`else
    assign out_count = '0;
`endif

endmodule

// File: tb/tb_trap_filter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_filter_ctrl
// Self-checking bench for trap_filter_ctrl. A reference model tracks the
// number of cycles since the last accepted valid configuration and derives
// the expected phase from that elapsed time.
// ---------------------------------------------------------------------------
module tb_trap_filter_ctrl;

    localparam int DW = 16;
    localparam int KW = 14;
    localparam int PL = 4;
    localparam int FC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          flt_aresetn;
    logic [KW-1:0] flt_kdelay;
    logic [KW-1:0] flt_ldelay;
    logic [15:0]   flt_mult;
    logic          flt_tvalid;
    logic [31:0]   flt_tdata;
    logic          m_axis_tvalid;
    logic [31:0]   m_axis_tdata;
    logic          busy;
    logic [1:0]    state;
    logic [31:0]   out_count;

    int compared = 0;
    int mismatched = 0;

    // Reference model: elapsed-time view of the controller.
    bit          mStarted;
    int          mT;
    int          mK, mL, mW;
    logic [15:0] mMult;
    bit          mErr;
    bit          mTvalid;
    logic [31:0] mTdata;
    longint      mCount;

    trap_filter_ctrl_if #(.DELAY_WIDTH(KW)) cfg_bus ();

    trap_filter_ctrl #(
        .DATA_WIDTH  (DW),
        .DELAY_WIDTH (KW),
        .PIPE_LAT    (PL),
        .FLUSH_CYC   (FC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_if        (cfg_bus),
        .flt_aresetn   (flt_aresetn),
        .flt_kdelay    (flt_kdelay),
        .flt_ldelay    (flt_ldelay),
        .flt_mult      (flt_mult),
        .flt_tvalid    (flt_tvalid),
        .flt_tdata     (flt_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .busy          (busy),
        .state         (state),
        .out_count     (out_count)
    );

    always #5 clk = ~clk;

    // Expected phase from the cycle index since the accepting edge:
    // cycles 1..FC flush, the next W cycles warm up, then run.
    function automatic int modelState();
        if (!mStarted)      return 0;
        if (mT <= FC)       return 1;
        if (mT <= FC + mW)  return 2;
        return 3;
    endfunction

    task automatic modelReset();
        mStarted = 0; mT = 0; mK = 0; mL = 0; mW = 0; mMult = '0;
        mErr = 0; mTvalid = 0; mTdata = '0; mCount = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h",
                     tag, $time, observed, expected);
        end
    endtask

    task automatic checkAll();
        int st;
        bit ready;
        st = modelState();
        ready = (st != 1);
        checkOutput("state", 64'(state), 64'(st));
        checkOutput("cfg_ready", 64'(cfg_bus.cfg_ready), 64'(ready));
        checkOutput("cfg_err", 64'(cfg_bus.cfg_err), 64'(mErr));
        checkOutput("flt_aresetn", 64'(flt_aresetn), 64'(st >= 2));
        checkOutput("busy", 64'(busy), 64'((st == 1) || (st == 2)));
        checkOutput("flt_kdelay", 64'(flt_kdelay), 64'(mK));
        checkOutput("flt_ldelay", 64'(flt_ldelay), 64'(mL));
        checkOutput("flt_mult", 64'(flt_mult), 64'(mMult));
        checkOutput("m_axis_tvalid", 64'(m_axis_tvalid), 64'(mTvalid));
        checkOutput("m_axis_tdata", 64'(m_axis_tdata), 64'(mTdata));
`ifdef TRAP_CTRL_STATS_EN
        checkOutput("out_count", 64'(out_count), 64'(mCount));
`else
        checkOutput("out_count", 64'(out_count), 64'd0);
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge and
    // compare all outputs one time unit later.
    task automatic applyStimulus(input bit rst, input bit v, input int k,
                                 input int l, input logic [15:0] mult,
                                 input bit ftv, input logic [31:0] ftd);
        int  st;
        bit  acc, ok, restart;
        reset              = rst;
        cfg_bus.cfg_valid  = v;
        cfg_bus.cfg_k      = KW'(k);
        cfg_bus.cfg_l      = KW'(l);
        cfg_bus.cfg_mult   = mult;
        flt_tvalid         = ftv;
        flt_tdata          = ftd;
        @(posedge clk);
        if (rst) begin
            modelReset();
        end else begin
            st      = modelState();
            acc     = v && (st != 1);
            ok      = (k >= 3) && (l >= k);
            restart = acc && ok;
            mErr    = acc && !ok;
            mTvalid = (st == 3) && !restart && ftv;
            if (st == 3) mTdata = ftd;
            if (restart) mCount = 0;
            else if (mTvalid && mCount < 64'hFFFF_FFFF) mCount++;
            if (restart) begin
                mStarted = 1;
                mT       = 1;
                mK       = k;
                mL       = l;
                mMult    = mult;
                mW       = k + l + 2 + PL;
            end else if (mStarted && mT < 1000000) begin
                mT++;
            end
        end
        #1;
        checkAll();
    endtask

    task automatic idleCycles(input int n, input bit ftv);
        for (int i = 0; i < n; i++)
            applyStimulus(0, 0, 0, 0, 16'h0, ftv, $urandom);
    endtask

    initial begin
        modelReset();

        // Reset state
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 0, 0, 0, 16'h0, 0, 32'h0);

        // Invalid K in IDLE
        applyStimulus(0, 1, 2, 20, 16'd7, 1, $urandom);
        idleCycles(3, 1);

        // K=10, L=20, mult=100: flush, 36-cycle warm-up, run
        applyStimulus(0, 1, 10, 20, 16'd100, 1, $urandom);
        idleCycles(55, 1);

        // Invalid L<K in RUN: stream keeps flowing
        applyStimulus(0, 1, 8, 4, 16'd9, 1, $urandom);
        idleCycles(5, 1);

        // K=5, L=5 in RUN, then a second request held through the flush
        applyStimulus(0, 1, 5, 5, 16'd55, 1, $urandom);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 1, 6, 9, 16'hFF00, 1, $urandom);
        idleCycles(40, 1);

        // Long continuous run for the beat counter, then clear it
        idleCycles(110, 1);
        applyStimulus(0, 1, 3, 3, 16'h8000, 1, $urandom);
        idleCycles(8, 1);

        // Reset while warming up, and a request coinciding with reset
        applyStimulus(1, 0, 0, 0, 16'h0, 1, $urandom);
        applyStimulus(0, 1, 12, 30, 16'd1, 1, $urandom);
        idleCycles(10, 1);
        applyStimulus(1, 1, 4, 4, 16'd2, 1, $urandom);
        idleCycles(3, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 999) == 0,
                          $urandom_range(0, 59) == 0,
                          $urandom_range(0, 12),
                          $urandom_range(0, 30),
                          16'($urandom),
                          $urandom_range(0, 3) != 0,
                          $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/trap_filter_ctrl.md
# trap_filter_ctrl

Sequencer and configuration owner for the trapezoidal filter. It accepts new shaping parameters (K, L, decay multiplier) through a valid/ready handshake and checks them. It then drives the filter's `Kdelay`/`Ldelay`/`mult_factor` and active-low `aresetn`, flushes and warms up the filter, and gates the filter's output stream so that downstream logic sees only settled samples. It sits between the PS-side register bank and the trap filter instance.

## Interface
- `DATA_WIDTH`, default 16: filter input sample width; output is 2*DATA_WIDTH.
- `DELAY_WIDTH`, default 14: width of K and L.
- `PIPE_LAT`, default 4: filter arithmetic latency added to the warm-up count.
- `FLUSH_CYC`, default 4: cycles that `flt_aresetn` is held low per reconfiguration.

- `clk`  in  1  single clock, all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cfg_k`  in  DELAY_WIDTH  requested rise/fall length K.
- `cfg_l`  in  DELAY_WIDTH  requested L (flat-top = L-K).
- `cfg_mult`  in  16  signed decay multiplier.
- `cfg_valid`  in  1  configuration request.
- `cfg_ready`  out  1  controller can accept a request.
- `cfg_err`  out  1  one-cycle pulse: accepted request was rejected.
- `flt_aresetn`  out  1  filter reset (active low).
- `flt_kdelay`, `flt_ldelay`  out  DELAY_WIDTH  live K, L to filter.
- `flt_mult`  out  16  live multiplier to filter.
- `flt_tvalid`  in  1  filter m_axis_tvalid.
- `flt_tdata`  in  2*DATA_WIDTH  filter m_axis_tdata.
- `m_axis_tvalid`  out  1  gated, registered output valid.
- `m_axis_tdata`  out  2*DATA_WIDTH  registered output data.
- `busy`  out  1  high in FLUSH or WARM.
- `state`  out  2  IDLE=0, FLUSH=1, WARM=2, RUN=3.
- `out_count`  out  32  settled output beat count (see Configuration).

## Operation
- Accept when `cfg_valid && cfg_ready`. `cfg_ready` = 1 in IDLE, WARM and RUN. It is 0 in FLUSH.
- Validity check: K ≥ 3 and L ≥ K.
  - Invalid request: still consumed. `cfg_err` pulses the next cycle. State, live parameters and outputs are unchanged.
- Valid request:
  - `flt_kdelay`/`flt_ldelay`/`flt_mult` update on the next edge.
  - The controller enters FLUSH from any state, including WARM and RUN.
- FLUSH:
  - `flt_aresetn` = 0 for exactly FLUSH_CYC cycles, then go to WARM.
- WARM:
  - Counter loads W = K + L + 2 + PIPE_LAT (DELAY_WIDTH+2 bits, no overflow).
  - It decrements every clock, independent of `flt_tvalid`.
  - When it reaches 1, the next state is RUN.
- RUN:
  - `m_axis_tvalid <= flt_tvalid`, `m_axis_tdata <= flt_tdata`.
  - Outside RUN, `m_axis_tvalid <= 0` and `m_axis_tdata` holds its value.
- IDLE (no valid config yet): `flt_aresetn` = 0 and output is gated.
- `flt_aresetn` = 1 only in WARM and RUN.

## Timing
- Reset values:
  - state IDLE.
  - `cfg_ready` = 1, `cfg_err` = 0, `flt_aresetn` = 0.
  - `flt_kdelay` = `flt_ldelay` = `flt_mult` = 0.
  - `m_axis_tvalid` = 0, `m_axis_tdata` = 0, `busy` = 0, `out_count` = 0.
- Cycle sequence for a valid request accepted at edge 0:
  - FLUSH during cycles 1..FLUSH_CYC.
  - WARM during the next W cycles.
  - RUN from cycle FLUSH_CYC+W+1.
  - First possible `m_axis_tvalid` one cycle after that.
- Output path latency is 1 cycle. There is no backpressure, matching the filter.
- Request in WARM or RUN restarts FLUSH immediately. The WARM counter is discarded.
- Request during FLUSH stalls on `cfg_ready` = 0 until WARM.
- `reset` mid-operation: all registers return to reset values next edge, and the filter is held in reset.
- Only a request accepted in the same cycle as `reset` is dropped. No `cfg_err` is raised for it.

## Configuration
- Macro `TRAP_CTRL_STATS_EN`.
- With the macro defined:
  - `out_count` increments on each RUN-state `m_axis_tvalid` beat and saturates at 2^32-1.
  - It clears on every entry to FLUSH.
- Without it: `out_count` is tied to 0 and no counter logic is built.

## Structure
- Package `trap_ctrl_pkg`:
  - state enum (IDLE/FLUSH/WARM/RUN, 2-bit encoding above).
  - `TRAP_MIN_K` = 3.
  - the warm-up width rule.
- One sub-module, `trap_warm_counter`:
  - loadable down-counter with load, enable and done (registered).
  - instantiated once for both FLUSH and WARM timing.

## Test plan
- Reset, then K=10, L=20, mult=100 at edge 0:
  - `flt_aresetn` low cycles 1–4.
  - WARM cycles 5–40 (W=36).
  - state=RUN at cycle 41.
  - With `flt_tvalid` held 1, first `m_axis_tvalid` at cycle 42, carrying the `flt_tdata` of cycle 41.
- K=2, L=20 in IDLE:
  - `cfg_err` = 1 for one cycle.
  - state stays IDLE, `flt_kdelay` stays 0.
  - Then K=8, L=4 in RUN: `cfg_err` pulses, live K/L unchanged, output stream uninterrupted.
- In RUN, apply K=5, L=5:
  - next cycle state=FLUSH and `m_axis_tvalid`=0.
  - `cfg_ready`=0 for 4 cycles.
  - WARM lasts 16 cycles.
- Request held during FLUSH:
  - not accepted until the first WARM cycle.
  - the counter then restarts: a second FLUSH begins.
- `reset` asserted mid-WARM: next cycle all outputs are at reset values and state=IDLE.
- With `TRAP_CTRL_STATS_EN`:
  - 100 valid beats in RUN give `out_count`=100.
  - a new valid request clears it to 0 at FLUSH entry.
  - Without the macro, `out_count` stays 0.
